addsub_serial: RTL and testbench

Parametrised multi-cycle signed/unsigned adder-subtractor. Processes `WIDTH`-bit operands `DIGIT` bits per clock, LSB first, through a single `DIGIT`-bit ripple slice with a registered carry. Offers a start/busy/done handshake, two's-complement overflow detection and optional signed saturation. It is the area-lean, width-generic successor to the fixed 4-bit combinational adder-subtractor, for datapaths that can tolerate `WIDTH/DIGIT` cycles of latency.

---
 rtl/addsub_serial_if.sv | 33 +++
 rtl/addsub_serial.sv | 129 ++++++++++++
 tb/tb_addsub_serial.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/addsub_serial_if.sv
// ============================================================================
// Module  : addsub_serial_if
// Brief   : Handshake/operand/result bundle for the serial adder-subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface addsub_serial_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic             sat;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             ovrflw;
    logic             cout;

    modport master (
        output start, a, b, m, sat,
        input  busy, done, y, ovrflw, cout
    );

    modport slave (
        input  start, a, b, m, sat,
        output busy, done, y, ovrflw, cout
    );
endinterface

`default_nettype wire

// File: rtl/addsub_serial.sv
// ============================================================================
// Module  : addsub_serial
// Brief   : Digit-serial signed/unsigned adder-subtractor, LSB first, with
//           start/busy/done handshake, overflow flag and optional saturation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    addsub_serial_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_ysh;
    logic [WIDTH-1:0] r_y;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_sat;
    logic             r_amsb;
    logic             r_ovf;
    logic             r_cout;

    logic [DIGIT:0]   w_sum;
    logic             w_cin_msb;
    logic             w_ovf;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_ysh_nxt;
    logic [WIDTH-1:0] w_res;

    assign w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};

    // Carry into the top bit of the digit recovered from its sum bit; on the
    // last digit this is the carry into the word MSB.
    assign w_cin_msb = w_sum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
    assign w_ovf     = w_cin_msb ^ w_sum[DIGIT];
    assign w_last    = (r_cnt == CW'(N - 1));
    assign w_accept  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign w_ysh_nxt = w_sum[DIGIT-1:0];
        end else begin : g_multi_digit
            assign w_ysh_nxt = {w_sum[DIGIT-1:0], r_ysh[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Overflow direction follows the sign of A for both add and subtract.
    assign w_res = (r_sat && w_ovf)
                 ? (r_amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                 : w_ysh_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_ysh   <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sat   <= 1'b0;
            r_amsb  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b ^ {WIDTH{bus.m}};
            r_carry <= bus.m;
            r_sat   <= bus.sat;
            r_amsb  <= bus.a[WIDTH-1];
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_ysh   <= w_ysh_nxt;
            r_carry <= w_sum[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_y    <= w_res;
                r_ovf  <= w_ovf;
                r_cout <= w_sum[DIGIT];
            end
        end
    end

    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);
    assign bus.y      = r_y;
    assign bus.ovrflw = r_ovf;
    assign bus.cout   = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_addsub_serial.sv
// ============================================================================
// Module  : tb_addsub_serial
// Brief   : Self-checking bench for addsub_serial (DIGIT=1 and DIGIT=4, WIDTH=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_serial;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_serial_if #(.WIDTH(W)) if1 ();
    addsub_serial_if #(.WIDTH(W)) if4 ();

    addsub_serial #(.WIDTH(W), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1.slave));
    addsub_serial #(.WIDTH(W), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4.slave));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  input logic m, input logic sat,
                                  output logic [7:0] y, output logic ov, output logic co);
        int sa, sb, r, u;
        logic [7:0] nb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = m ? (sa - sb) : (sa + sb);
        ov = (r > 127) || (r < -128);
        nb = m ? ~b : b;
        u  = int'(a) + int'(nb) + int'(m);
        co = (u > 255);
        y  = 8'(u);
        if (sat && ov) y = (r > 0) ? 8'h7F : 8'h80;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [7:0] a,
                         input logic [7:0] b, input logic m, input logic sat);
        if (sel == 1) begin
            if1.start = st; if1.a = a; if1.b = b; if1.m = m; if1.sat = sat;
        end else begin
            if4.start = st; if4.a = a; if4.b = b; if4.m = m; if4.sat = sat;
        end
    endtask

    function automatic logic get_busy(input int sel); return (sel == 1) ? if1.busy : if4.busy; endfunction
    function automatic logic get_done(input int sel); return (sel == 1) ? if1.done : if4.done; endfunction
    function automatic logic [7:0] get_y(input int sel); return (sel == 1) ? if1.y : if4.y; endfunction
    function automatic logic get_ovf(input int sel); return (sel == 1) ? if1.ovrflw : if4.ovrflw; endfunction
    function automatic logic get_cout(input int sel); return (sel == 1) ? if1.cout : if4.cout; endfunction

    task automatic wait_done(input int sel, input int max, output int cyc);
        cyc = 0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (get_done(sel)) break;
        end
    endtask

    task automatic check_result(input int sel, input string tag, input logic [7:0] a,
                                input logic [7:0] b, input logic m, input logic sat);
        logic [7:0] ey;
        logic eo, ec;
        model(a, b, m, sat, ey, eo, ec);
        check({tag, " y"},      get_y(sel),    32'(ey));
        check({tag, " ovrflw"}, get_ovf(sel),  32'(eo));
        check({tag, " cout"},   get_cout(sel), 32'(ec));
    endtask

    // Full operation starting from an idle cycle; operands are scrambled after acceptance.
    task automatic op(input int sel, input int n, input string tag, input logic [7:0] a,
                      input logic [7:0] b, input logic m, input logic sat);
        int cyc;
        drive(sel, 1'b1, a, b, m, sat);
        @(posedge clk); #1;
        drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        check({tag, " busy"}, get_busy(sel), 32'd1);
        wait_done(sel, n + 4, cyc);
        check({tag, " latency"}, cyc, n);
        check_result(sel, tag, a, b, m, sat);
        @(posedge clk); #1;
        check({tag, " done pulse width"}, get_done(sel), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and idle behaviour.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            for (int s = 1; s <= 4; s += 3) begin
                check("idle busy",   get_busy(s), 32'd0);
                check("idle done",   get_done(s), 32'd0);
                check("idle y",      get_y(s),    32'd0);
                check("idle ovrflw", get_ovf(s),  32'd0);
                check("idle cout",   get_cout(s), 32'd0);
            end
        end

        // Directed cases, DIGIT=1.
        op(1, 8, "add 100+27",   8'd100, 8'd27,  1'b0, 1'b0);
        op(1, 8, "add 100+28",   8'd100, 8'd28,  1'b0, 1'b0);
        op(1, 8, "sub 5-3",      8'd5,   8'd3,   1'b1, 1'b0);
        op(1, 8, "sub 3-5",      8'd3,   8'd5,   1'b1, 1'b0);
        op(1, 8, "sub 80-01",    8'h80,  8'h01,  1'b1, 1'b0);
        op(1, 8, "sat 100+28",   8'd100, 8'd28,  1'b0, 1'b1);
        op(1, 8, "sat 80-01",    8'h80,  8'h01,  1'b1, 1'b1);
        op(1, 8, "sat 80+FF",    8'h80,  8'hFF,  1'b0, 1'b1);
        check("sat 80+FF y const", get_y(1), 32'h80);

        // DIGIT=4.
        op(4, 2, "d4 7F+01", 8'h7F, 8'h01, 1'b0, 1'b0);
        check("d4 7F+01 y const", get_y(4), 32'h80);

        // Start held high: second op accepted on the edge leaving DONE.
        drive(4, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(4, 1'b1, 8'h10, 8'h05, 1'b1, 1'b0);
        wait_done(4, 6, cyc);
        check("held first latency", cyc, 2);
        check_result(4, "held first", 8'h7F, 8'h01, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("held re-accept busy", get_busy(4), 32'd1);
        check("held re-accept done", get_done(4), 32'd0);
        drive(4, 1'b0, 8'hAA, 8'h55, 1'b0, 1'b1);
        wait_done(4, 6, cyc);
        check("held second latency", cyc, 2);
        check_result(4, "held second", 8'h10, 8'h05, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Start pulse while busy is ignored.
        drive(1, 1'b1, 8'd10, 8'd20, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        drive(1, 1'b1, 8'd99, 8'd1, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(1, 1'b0, 8'd77, 8'd33, 1'b1, 1'b0);
        wait_done(1, 10, cyc);
        check("busy-start latency", cyc, 5);
        check_result(1, "busy-start", 8'd10, 8'd20, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("busy-start not queued", get_busy(1), 32'd0);
        end

        // Produce nonzero flags, then reset in the middle of an operation.
        op(1, 8, "pre-reset", 8'h80, 8'hFF, 1'b0, 1'b0);
        drive(1, 1'b1, 8'd50, 8'd60, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("abort busy",   get_busy(1), 32'd0);
        check("abort y",      get_y(1),    32'd0);
        check("abort ovrflw", get_ovf(1),  32'd0);
        check("abort cout",   get_cout(1), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("abort no done", get_done(1), 32'd0);
        end
        op(1, 8, "post-reset", 8'h12, 8'h34, 1'b0, 1'b0);

        // Randomized operations on both configurations.
        for (int i = 0; i < 20; i++) begin
            op(1, 8, "rand d1", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            op(4, 2, "rand d4", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
